reg_wb_arbiter: RTL
===================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, entries in the long-latency result queue (power of two, 2..8).
REQ-002 Parameter: STARVE_LIMIT, default 7, head-wait cycles before a stall request.
REQ-003 CLK  input  1  clock, all state on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 PIPE_WE  input  1  main-pipeline writeback request, always accepted.
REQ-006 PIPE_RD  input  5  main-pipeline destination register.
REQ-007 PIPE_DATA  input  32  main-pipeline result.
REQ-008 LONG_VALID  input  1  long-latency unit (mul/div) result valid.
REQ-009 LONG_RD  input  5  long-latency destination register.
REQ-010 LONG_DATA  input  32  long-latency result.
REQ-011 LONG_READY  output  1  queue can accept a push this cycle.
REQ-012 Query_reg  input  5  register number probed by the hazard unit.
REQ-013 Query_pending  output  1  write to Query_reg still outstanding.
REQ-014 RegWrite  output  1  register-file write enable.
REQ-015 Write_register  output  5  register-file write address.
REQ-016 Write_Data  output  32  register-file write data.
REQ-017 STALL_REQ  output  1  request one pipeline writeback bubble.
REQ-018 FIFO_COUNT  output  4  current queue occupancy.

Function
REQ-019 Block SHALL be the sole driver of the register-file write port; RegWrite/Write_register/Write_Data SHALL be registered, one cycle after the selected source.
REQ-020 Per cycle, priority: (a) PIPE_WE=1 and PIPE_RD!=0 -> issue pipe write; (b) else queue non-empty -> pop head and issue it; (c) else RegWrite=0 next cycle, address/data hold previous values.
REQ-021 PIPE_WE=1 with PIPE_RD=0 SHALL produce no write and SHALL NOT block a queue pop that cycle.
REQ-022 LONG_READY SHALL equal (FIFO_COUNT < FIFO_DEPTH), combinational from count only (simultaneous pop not credited).
REQ-023 Push occurs when LONG_VALID=1 and LONG_READY=1; LONG_RD=0 push SHALL be accepted but discarded (no entry, no count change).
REQ-024 LONG_VALID=1 while LONG_READY=0 SHALL be ignored; queue contents unchanged.
REQ-025 Simultaneous push and pop SHALL leave FIFO_COUNT unchanged; order strictly FIFO; pointers wrap modulo FIFO_DEPTH.
REQ-026 Push to empty queue SHALL NOT be poppable until the following cycle (no same-cycle bypass).
REQ-027 AGE counter: increments each cycle queue non-empty and no pop; cleared on pop or when empty; saturates at STARVE_LIMIT.
REQ-028 STALL_REQ SHALL be registered, 1 in the cycle after AGE reaches STARVE_LIMIT, 0 the cycle after the next pop.
REQ-029 Query_pending SHALL be combinational: 1 if Query_reg!=0 and (any valid queue entry has rd=Query_reg, or RegWrite=1 and Write_register=Query_reg); else 0.
REQ-030 Query_reg=0 SHALL always give Query_pending=0.

Reset
REQ-031 RESET=1 SHALL immediately clear: RegWrite=0, Write_register=0, Write_Data=0, STALL_REQ=0, FIFO_COUNT=0, AGE=0, all entries invalid, pointers 0.
REQ-032 Reset mid-operation SHALL discard all queued results; LONG_READY=1 while RESET=1 and after release.
REQ-033 First write SHALL be possible on the first rising edge after RESET deasserts.

Verification
REQ-034 PIPE_WE=1, PIPE_RD=8, PIPE_DATA=0x0000_0005 -> next cycle RegWrite=1, Write_register=8, Write_Data=0x5; following idle cycle RegWrite=0.
REQ-035 Push LONG_RD=9/0xAAAA_0001 with PIPE_WE=0 -> FIFO_COUNT=1 next cycle, then pop: RegWrite=1, Write_register=9, Write_Data=0xAAAA_0001, FIFO_COUNT=0.
REQ-036 Push 4 entries (rd 10..13) with PIPE_WE=1 rd=8 continuously -> FIFO_COUNT=4, LONG_READY=0, 5th push ignored, STALL_REQ=1 after 7 blocked cycles; drop PIPE_WE -> writes 10,11,12,13 in order, STALL_REQ clears after first pop.
REQ-037 Queue holds rd=17, Query_reg=17 -> Query_pending=1; Query_reg=0 -> 0; after entry written and RegWrite drops -> 0.
REQ-038 PIPE_WE=1 rd=0 with queue head rd=5 -> rd=5 written next cycle, no write to register 0; LONG_RD=0 push leaves FIFO_COUNT unchanged.
REQ-039 Assert RESET with FIFO_COUNT=3 mid-stream -> FIFO_COUNT=0, RegWrite=0, STALL_REQ=0 immediately; no stale entry written after release.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// ----------------------------------------------------------------------------
// reg_wb_arbiter
//   Owns the register-file write port. Each cycle it picks one write source:
//   a main-pipeline writeback has priority, and otherwise the oldest queued
//   long-latency (mul/div) result is drained. If the queue head waits too long,
//   the block asks the pipeline for a writeback bubble. The hazard unit can ask
//   whether a write to a given register is still outstanding.
//
// Parameters
//   FIFO_DEPTH    entries in the long-latency result queue (power of two, 2..8)
//   STARVE_LIMIT  cycles the queue head may wait before a stall request
//
// Ports
//   CLK, RESET                         clock; asynchronous active-high reset
//   PIPE_WE / PIPE_RD / PIPE_DATA      main-pipeline writeback request
//   LONG_VALID / LONG_RD / LONG_DATA   long-latency result push
//   LONG_READY                         queue can accept a push this cycle
//   Query_reg / Query_pending          hazard-unit probe of outstanding writes
//   RegWrite / Write_register / Write_Data   registered register-file port
//   STALL_REQ                          registered request for a writeback bubble
//   FIFO_COUNT                         current queue occupancy
// ----------------------------------------------------------------------------
module reg_wb_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 7
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PIPE_WE,
    input  logic [4:0]  PIPE_RD,
    input  logic [31:0] PIPE_DATA,
    input  logic        LONG_VALID,
    input  logic [4:0]  LONG_RD,
    input  logic [31:0] LONG_DATA,
    output logic        LONG_READY,
    input  logic [4:0]  Query_reg,
    output logic        Query_pending,
    output logic        RegWrite,
    output logic [4:0]  Write_register,
    output logic [31:0] Write_Data,
    output logic        STALL_REQ,
    output logic [3:0]  FIFO_COUNT
);

    localparam int PTR_W = (FIFO_DEPTH <= 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    // Queue storage and bookkeeping
    logic [4:0]            mem_rd_r   [0:FIFO_DEPTH-1];
    logic [31:0]           mem_data_r [0:FIFO_DEPTH-1];
    logic [FIFO_DEPTH-1:0] valid_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [3:0]            count_r;
    logic [AGE_W-1:0]      age_r;

    // Registered outputs
    logic                  reg_write_r;
    logic [4:0]            write_register_r;
    logic [31:0]           write_data_r;
    logic                  stall_req_r;

    // Per-cycle decisions
    logic                  ready_s;
    logic                  pipe_wr_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  queue_hit_s;

    // Source selection: ready is judged on the registered count only, so a
    // push into an empty queue cannot be popped until the next cycle.
    always_comb begin
        ready_s   = (count_r < 4'(FIFO_DEPTH));
        pipe_wr_s = PIPE_WE && (PIPE_RD != 5'd0);
        // A result for r0 is accepted (handshake completes) but never stored.
        push_s    = LONG_VALID && ready_s && (LONG_RD != 5'd0);
        pop_s     = !pipe_wr_s && (count_r != 4'd0);
    end

    // Hazard probe: any live queue entry or the write now on the port.
    always_comb begin
        queue_hit_s = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            queue_hit_s = queue_hit_s | (valid_r[i] & (mem_rd_r[i] == Query_reg));
        end
        if (Query_reg == 5'd0) begin
            Query_pending = 1'b0;
        end else begin
            Query_pending = queue_hit_s | (reg_write_r & (write_register_r == Query_reg));
        end
    end

    // Queue storage, pointers and occupancy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 4'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_rd_r[i]   <= 5'd0;
                mem_data_r[i] <= 32'd0;
            end
        end else begin
            // Push and pop never target the same slot: push needs a free slot,
            // pop needs an occupied one, and wr_ptr == rd_ptr only when the
            // queue is wholly empty or wholly full.
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s) begin
                valid_r[wr_ptr_r]    <= 1'b1;
                mem_rd_r[wr_ptr_r]   <= LONG_RD;
                mem_data_r[wr_ptr_r] <= LONG_DATA;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head-of-queue age and the starvation stall request.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            age_r       <= '0;
            stall_req_r <= 1'b0;
        end else begin
            if (pop_s || (count_r == 4'd0)) begin
                age_r <= '0;
            end else if (age_r < AGE_W'(STARVE_LIMIT)) begin
                age_r <= age_r + AGE_W'(1);
            end else begin
                age_r <= age_r;
            end
            // A pop in the same cycle wins over a newly reached limit.
            if (pop_s) begin
                stall_req_r <= 1'b0;
            end else if (age_r == AGE_W'(STARVE_LIMIT)) begin
                stall_req_r <= 1'b1;
            end else begin
                stall_req_r <= stall_req_r;
            end
        end
    end

    // Register-file write port; address/data hold when no write is issued.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            reg_write_r      <= 1'b0;
            write_register_r <= 5'd0;
            write_data_r     <= 32'd0;
        end else if (pipe_wr_s) begin
            reg_write_r      <= 1'b1;
            write_register_r <= PIPE_RD;
            write_data_r     <= PIPE_DATA;
        end else if (pop_s) begin
            reg_write_r      <= 1'b1;
            write_register_r <= mem_rd_r[rd_ptr_r];
            write_data_r     <= mem_data_r[rd_ptr_r];
        end else begin
            reg_write_r      <= 1'b0;
            write_register_r <= write_register_r;
            write_data_r     <= write_data_r;
        end
    end

    assign LONG_READY     = ready_s;
    assign FIFO_COUNT     = count_r;
    assign RegWrite       = reg_write_r;
    assign Write_register = write_register_r;
    assign Write_Data     = write_data_r;
    assign STALL_REQ      = stall_req_r;

endmodule
